// File: rtl/alsu_logic_result_stage.sv
// Registered output stage for the ALSU logic group (NAND/NOR/complement).
// Captures each mux result with its select tag, derives zero/parity/sign
// flags at capture time and holds up to two results in a skid buffer so the
// writeback path can stall without losing data. Also keeps a saturating
// count of accepted results for debug.
module alsu_logic_result_stage #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 In_Valid,
   output logic                 In_Ready,
   input  logic [WIDTH-1:0]     In_Result,
   input  logic [1:0]           In_Sel,
   input  logic                 Flush,
   output logic                 Out_Valid,
   input  logic                 Out_Ready,
   output logic [WIDTH-1:0]     Out_Result,
   output logic [1:0]           Out_Tag,
   output logic                 Out_Zero,
   output logic                 Out_Parity,
   output logic                 Out_Neg,
   output logic [CNT_WIDTH-1:0] Acc_Count
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [1:0]       tag;
      logic             zero;
      logic             parity;
      logic             neg;
   } entry_t;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StFull  = 2'd2
   } occ_e;

   occ_e                 occ_q;
   entry_t               head_q;
   entry_t               tail_q;
   entry_t               new_entry;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic                 push;
   logic                 pop;

   // Build the candidate entry; flags are fixed here and never recomputed.
   always_comb begin
      new_entry        = '0;
      new_entry.result = In_Result;
      new_entry.tag    = In_Sel;
      new_entry.zero   = (In_Result == '0);
      new_entry.parity = ^In_Result;
      new_entry.neg    = In_Result[WIDTH-1];
   end

   assign In_Ready  = (occ_q != StFull);
   assign Out_Valid = (occ_q != StEmpty);
   assign push      = In_Valid && In_Ready;
   assign pop       = Out_Valid && Out_Ready;

   // Occupancy FSM and entry storage. Vacated slots are cleared so the
   // outputs read zero while empty and stale data is never exposed.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         occ_q  <= StEmpty;
         head_q <= '0;
         tail_q <= '0;
      end else if (Flush) begin
         occ_q  <= StEmpty;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (occ_q)
            StEmpty: begin
               if (push) begin
                  head_q <= new_entry;
                  occ_q  <= StOne;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_q <= new_entry;
               end else if (push) begin
                  tail_q <= new_entry;
                  occ_q  <= StFull;
               end else if (pop) begin
                  head_q <= '0;
                  occ_q  <= StEmpty;
               end
            end
            StFull: begin
               // In_Ready is low here, so only a pop can happen.
               if (pop) begin
                  head_q <= tail_q;
                  tail_q <= '0;
                  occ_q  <= StOne;
               end
            end
            default: begin
               occ_q  <= StEmpty;
               head_q <= '0;
               tail_q <= '0;
            end
         endcase
      end
   end

   // Saturating count of accepted pushes; a push dropped by Flush is not counted.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q <= '0;
      end else if (push && !Flush && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign Out_Result = head_q.result;
   assign Out_Tag    = head_q.tag;
   assign Out_Zero   = head_q.zero;
   assign Out_Parity = head_q.parity;
   assign Out_Neg    = head_q.neg;
   assign Acc_Count  = cnt_q;

endmodule

// File: tb/tb_alsu_logic_result_stage.sv
// Self-checking bench for alsu_logic_result_stage: directed steps drive a
// scoreboard queue that models the two-entry buffer and the push counter.
module tb_alsu_logic_result_stage;

   logic       Clk;
   logic       Rst_n;
   logic       In_Valid;
   logic       In_Ready;
   logic [3:0] In_Result;
   logic [1:0] In_Sel;
   logic       Flush;
   logic       Out_Valid;
   logic       Out_Ready;
   logic [3:0] Out_Result;
   logic [1:0] Out_Tag;
   logic       Out_Zero;
   logic       Out_Parity;
   logic       Out_Neg;
   logic [7:0] Acc_Count;

   typedef struct packed {
      logic [3:0] r;
      logic [1:0] t;
      logic       z;
      logic       p;
      logic       n;
   } exp_t;

   exp_t     sb_q[$];
   int       cnt_m;
   int       n_cmp;
   int       n_err;

   alsu_logic_result_stage #(
      .WIDTH     (4),
      .CNT_WIDTH (8)
   ) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .In_Valid   (In_Valid),
      .In_Ready   (In_Ready),
      .In_Result  (In_Result),
      .In_Sel     (In_Sel),
      .Flush      (Flush),
      .Out_Valid  (Out_Valid),
      .Out_Ready  (Out_Ready),
      .Out_Result (Out_Result),
      .Out_Tag    (Out_Tag),
      .Out_Zero   (Out_Zero),
      .Out_Parity (Out_Parity),
      .Out_Neg    (Out_Neg),
      .Acc_Count  (Acc_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] r, input logic [1:0] t);
      exp_t e;
      e.r = r;
      e.t = t;
      e.z = (r == 4'd0);
      e.p = r[0] ^ r[1] ^ r[2] ^ r[3];
      e.n = r[3];
      return e;
   endfunction

   // Check the head and handshake outputs, then advance one clock and update the model.
   task automatic cycle(input logic v, input logic [3:0] r, input logic [1:0] s,
                        input logic ordy, input logic fl);
      exp_t head_e;
      logic push_m;
      logic pop_m;
      In_Valid  = v;
      In_Result = r;
      In_Sel    = s;
      Out_Ready = ordy;
      Flush     = fl;
      #1;
      head_e = (sb_q.size() != 0) ? sb_q[0] : '0;
      check("in_ready", {31'd0, In_Ready}, {31'd0, sb_q.size() != 2});
      check("out_valid", {31'd0, Out_Valid}, {31'd0, sb_q.size() != 0});
      check("head", {23'd0, Out_Result, Out_Tag, Out_Zero, Out_Parity, Out_Neg},
            {23'd0, head_e});
      push_m = v && (sb_q.size() != 2);
      pop_m  = (sb_q.size() != 0) && ordy;
      @(posedge Clk);
      #1;
      if (fl) begin
         sb_q.delete();
      end else begin
         if (pop_m) void'(sb_q.pop_front());
         if (push_m) begin
            sb_q.push_back(mk(r, s));
            if (cnt_m < 255) cnt_m++;
         end
      end
      check("acc_count", {24'd0, Acc_Count}, cnt_m);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'd0, In_Ready}, 32'd1);
      check({tag, "_valid"}, {31'd0, Out_Valid}, 32'd0);
      check({tag, "_head"}, {23'd0, Out_Result, Out_Tag, Out_Zero, Out_Parity, Out_Neg}, 32'd0);
      check({tag, "_count"}, {24'd0, Acc_Count}, 32'd0);
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      cnt_m     = 0;
      Rst_n     = 1'b0;
      In_Valid  = 1'b0;
      In_Result = 4'd0;
      In_Sel    = 2'd0;
      Flush     = 1'b0;
      Out_Ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      check_reset_outputs("reset");
      @(negedge Clk);
      Rst_n = 1'b1;

      // Zero result with tag 2 straight after reset release, then drain it.
      cycle(1'b1, 4'h0, 2'd2, 1'b1, 1'b0);
      cycle(1'b0, 4'hx, 2'bxx, 1'b1, 1'b0);

      // Stall downstream, fill both entries, try a third push, then drain.
      cycle(1'b1, 4'hB, 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 4'h7, 2'd3, 1'b0, 1'b0);
      cycle(1'b1, 4'h5, 2'd1, 1'b0, 1'b0);
      cycle(1'b0, 4'hx, 2'bxx, 1'b0, 1'b0);
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
      cycle(1'b0, 4'hx, 2'bxx, 1'b1, 1'b0);

      // Occupancy one, then simultaneous push and pop.
      cycle(1'b1, 4'h9, 2'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'h3, 2'd2, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 2'd0, 1'b0, 1'b0);

      // Fill, then Flush together with In_Valid: push dropped and not counted.
      cycle(1'b1, 4'hE, 2'd3, 1'b0, 1'b0);
      cycle(1'b1, 4'h6, 2'd0, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);

      // Flush while holding one entry and offering a push to an accepting stage.
      cycle(1'b1, 4'hC, 2'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'h1, 2'd2, 1'b0, 1'b1);
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);

      // Counter saturation: 300 back-to-back pushes with a data pattern.
      for (int i = 0; i < 300; i++) begin
         cycle(1'b1, 4'(i), 2'(i >> 4), 1'b1, 1'b0);
      end
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);

      // Asynchronous reset with two entries buffered, asserted between edges.
      cycle(1'b1, 4'hA, 2'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'h4, 2'd2, 1'b0, 1'b0);
      In_Valid = 1'b0;
      #2;
      Rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      sb_q.delete();
      cnt_m = 0;
      @(posedge Clk);
      #1;
      check_reset_outputs("reset_held");
      @(negedge Clk);
      Rst_n = 1'b1;
      cycle(1'b1, 4'h8, 2'd3, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);
      cycle(1'b0, 4'h0, 2'd0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alsu_logic_result_stage.md
Name: alsu_logic_result_stage

Overview:
- Registered output stage directly downstream of the NAND/NOR/complement group's 4:1 result mux.
- Captures each 4-bit logic result together with its 2-bit select tag.
- Derives status flags (zero, parity, sign) at capture time.
- Buffers up to two results in a skid buffer with valid/ready handshakes on both sides, so the ALSU writeback path can stall without losing results.
- Keeps a saturating count of accepted results for debug and verification.

Parameters:
WIDTH, 4, result data width. All flag rules below scale with WIDTH.
CNT_WIDTH, 8, width of the accepted-result counter.

Ports:
Clk  input  1  rising-edge clock.
Rst_n  input  1  asynchronous active-low reset.
In_Valid  input  1  upstream result valid.
In_Ready  output  1  stage can accept; equals (occupancy != 2); combinational from state registers only.
In_Result  input  WIDTH  result from the logic-group mux output.
In_Sel  input  2  select value used to produce In_Result; stored as the tag.
Flush  input  1  synchronous clear of buffered entries.
Out_Valid  output  1  head entry present; equals (occupancy != 0).
Out_Ready  input  1  downstream accepts the head entry.
Out_Result  output  WIDTH  head entry data.
Out_Tag  output  2  head entry tag.
Out_Zero  output  1  head entry result == 0.
Out_Parity  output  1  XOR-reduction of head entry result (1 = odd number of ones).
Out_Neg  output  1  MSB of head entry result.
Acc_Count  output  CNT_WIDTH  number of accepted pushes, saturating.

Behaviour:
- Storage: two entries (head, tail). Each entry holds {result, tag, zero, parity, neg}. Occupancy is a 2-bit state: EMPTY(0), ONE(1), FULL(2).
- Push: In_Valid && In_Ready at a rising edge. Pop: Out_Valid && Out_Ready at a rising edge.
- Flags are computed from In_Result at push time and stored. Outputs never recompute flags.
- Latency: a result pushed into EMPTY appears on Out_* in the cycle after the push edge (1-cycle latency). Out_Valid rises in that same cycle.
- Ordering: strict FIFO.
- State transitions:
  - EMPTY + push → ONE; entry written to head.
  - ONE + push only → FULL; entry written to tail.
  - ONE + pop only → EMPTY.
  - ONE + push + pop (simultaneous) → ONE; head replaced by the new entry.
  - FULL + pop → ONE; tail moves to head. No push is possible in FULL because In_Ready = 0.
  - EMPTY + pop is impossible because Out_Valid = 0.
- Out_* drive while EMPTY: Out_Result, Out_Tag and all flags are 0. Stale data is never exposed.
- Out_* stability: while Out_Valid = 1 and Out_Ready = 0, all Out_* values stay stable.
- Flush:
  - Next state is EMPTY; stored entries are discarded.
  - Flush has priority over push and pop in the same cycle. A push coinciding with Flush is dropped.
  - A push coinciding with Flush is not counted in Acc_Count.
  - Acc_Count is otherwise unaffected by Flush.
- Acc_Count: increments by 1 on every counted push and saturates at 2^CNT_WIDTH-1. It does not wrap.
- Reset (Rst_n low, asynchronous):
  - Occupancy = EMPTY; all entry registers = 0; Acc_Count = 0.
  - Resulting outputs: In_Ready = 1, Out_Valid = 0, Out_Result/Out_Tag/Out_Zero/Out_Parity/Out_Neg = 0.
  - Reset asserted mid-transfer discards all buffered entries. Outputs take reset values immediately, without waiting for a clock edge.
- Reset release: operation resumes on the first rising edge with Rst_n high. A push on that edge is accepted.
- Input checks: X on In_Result or In_Sel while In_Valid = 0 must not corrupt state.

Test Plan:
- Reset, then push In_Result=4'b0000, In_Sel=2 with Out_Ready=1 → next cycle Out_Valid=1, Out_Result=0, Out_Tag=2, Out_Zero=1, Out_Parity=0, Out_Neg=0. Acc_Count=1.
- Hold Out_Ready=0 and push 4'hB (tag 0), then 4'h7 (tag 3) → In_Ready=0 after the 2nd push. A 3rd In_Valid is not accepted. Out_* hold 4'hB/Parity=1/Neg=1. Raise Out_Ready → 4'hB then 4'h7 (Parity=1, Neg=0). In_Ready returns to 1 after the first pop.
- Occupancy ONE, then simultaneous push 4'h3 and pop → Out_Result=4'h3 next cycle, Out_Valid stays 1, Acc_Count +1.
- State FULL, assert Flush together with In_Valid → next cycle Out_Valid=0, Out_* all 0, In_Ready=1, Acc_Count unchanged.
- CNT_WIDTH=8: perform 300 pushes with Out_Ready=1 → Acc_Count=255 and held there.
- With 2 entries buffered, drop Rst_n asynchronously between clock edges → Out_Valid=0, Out_Result=0, Acc_Count=0 before the next edge. After release, a new push appears 1 cycle later.
